// File: rtl/ring_johnson_counter.sv
// Selectable ring / Johnson shift counter: rj=0 rotates a single one, rj=1 shifts in the inverted MSB.
// Optional macro RJ_SELF_CORRECT_EN clears q on any edge where it is illegal for the selected mode.
module ring_johnson_counter #(
    parameter int unsigned WIDTH = 4
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             rst,
    input  logic             rj
);

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("ring_johnson_counter: WIDTH must be in 2..32");
    end

    mode_e            mode;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] ring_next;
    logic [WIDTH-1:0] john_next;

    assign mode = mode_e'(rj);

    always_comb begin
        ring_next = '0;
        john_next = '0;
        if (state_q == '0) begin
            ring_next = ONE;
        end else begin
            ring_next = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
        end
        john_next = {state_q[WIDTH-2:0], ~state_q[WIDTH-1]};
    end

`ifdef RJ_SELF_CORRECT_EN
    logic [WIDTH-1:0] state_dec;
    logic [WIDTH-1:0] state_inc;
    logic [WIDTH-1:0] state_inv;
    logic [WIDTH-1:0] state_inv_inc;
    logic             ring_legal;
    logic             john_legal;

    // One-hot-or-zero: clearing the lowest set bit leaves nothing.
    // Johnson-legal: q or ~q has the form 0..01..1, i.e. x & (x+1) == 0.
    always_comb begin
        state_dec     = state_q - ONE;
        state_inc     = state_q + ONE;
        state_inv     = ~state_q;
        state_inv_inc = state_inv + ONE;
        ring_legal    = ((state_q & state_dec) == '0);
        john_legal    = ((state_q & state_inc) == '0) || ((state_inv & state_inv_inc) == '0);
    end

    always_comb begin
        state_d = '0;
        unique case (mode)
            MODE_RING:    state_d = ring_legal ? ring_next : '0;
            MODE_JOHNSON: state_d = john_legal ? john_next : '0;
            default:      state_d = '0;
        endcase
    end
`else
    always_comb begin
        state_d = '0;
        unique case (mode)
            MODE_RING:    state_d = ring_next;
            MODE_JOHNSON: state_d = john_next;
            default:      state_d = '0;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Scoreboard bench for ring_johnson_counter: WIDTH=4 and WIDTH=8 instances share clk/rst/rj.
module tb_ring_johnson_counter;

    logic       clk;
    logic       rst;
    logic       rj;
    logic [3:0] q4;
    logic [7:0] q8;

    int unsigned n_vec;
    int unsigned n_err;

    logic [31:0] m4;
    logic [31:0] m8;

    typedef struct {
        string       tag;
        logic [31:0] e4;
        logic [31:0] e8;
    } sb_t;

    sb_t sb[$];

    ring_johnson_counter #(.WIDTH(4)) dut4 (
        .q   (q4),
        .clk (clk),
        .rst (rst),
        .rj  (rj)
    );

    ring_johnson_counter #(.WIDTH(8)) dut8 (
        .q   (q8),
        .clk (clk),
        .rst (rst),
        .rj  (rj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, need completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference next state for a w-bit counter, written from the mode rules.
    function automatic logic [31:0] nxt(input logic [31:0] s, input int unsigned w, input logic j);
        logic [31:0] mask;
        int unsigned edges;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        edges = 0;
`ifdef RJ_SELF_CORRECT_EN
        if (!j && $countones(s) > 1) return 32'd0;
        if (j) begin
            for (int unsigned i = 1; i < w; i++)
                if (s[i] != s[i-1]) edges++;
            if (edges > 1) return 32'd0;
        end
`endif
        if (!j) begin
            if (s == 32'd0) return 32'd1;
            return ((s << 1) | (s >> (w - 1))) & mask;
        end
        return ((s << 1) | {31'd0, ~s[w-1]}) & mask;
    endfunction

    task automatic step(input string tag, input logic mode);
        sb_t e;
        rj = mode;
        if (rst) begin
            m4 = nxt(m4, 4, mode);
            m8 = nxt(m8, 8, mode);
        end else begin
            m4 = 32'd0;
            m8 = 32'd0;
        end
        e.tag = tag;
        e.e4  = m4;
        e.e8  = m8;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, "_q4"}, {28'd0, q4}, e.e4);
        check({e.tag, "_q8"}, {24'd0, q8}, e.e8);
    endtask

    // Assert reset between edges (caller is 1 after a posedge) and check q clears at once.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b0;
        m4  = 32'd0;
        m8  = 32'd0;
        #1;
        check({tag, "_q4"}, {28'd0, q4}, 32'd0);
        check({tag, "_q8"}, {24'd0, q8}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m4    = 32'd0;
        m8    = 32'd0;
        rst   = 1'b0;
        rj    = 1'b0;
        #2;
        check("por_q4", {28'd0, q4}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) step("rst_hold", i[0]);

        rst = 1'b1;
        for (int i = 0; i < 6; i++) step("ring", 1'b0);
        check("ring_end", {28'd0, q4}, 32'h2);

        async_reset("async_ring");
        for (int i = 0; i < 9; i++) step("john", 1'b1);
        check("john_end", {28'd0, q4}, 32'h1);

        async_reset("rst_sw");
        for (int i = 0; i < 3; i++) step("sw_ring", 1'b0);
        check("sw_at0100", {28'd0, q4}, 32'h4);
        step("sw_john1", 1'b1);
`ifdef RJ_SELF_CORRECT_EN
        check("sw_first", {28'd0, q4}, 32'h0);
`else
        check("sw_first", {28'd0, q4}, 32'h9);
`endif
        step("sw_john2", 1'b1);

        async_reset("rst_mid0");
        for (int i = 0; i < 3; i++) step("mid_john", 1'b1);
        check("mid_at0111", {28'd0, q4}, 32'h7);
        async_reset("rst_mid");
        step("mid_release", 1'b0);
        check("mid_seed", {28'd0, q4}, 32'h1);

        async_reset("rst_w8");
        for (int i = 1; i <= 16; i++) begin
            step("w8_john", 1'b1);
            if (i == 7) check("w8_msb_c7", {31'd0, q8[7]}, 32'd0);
            if (i == 8) check("w8_msb_c8", {31'd0, q8[7]}, 32'd1);
        end
        check("w8_period", {24'd0, q8}, 32'h00);

        for (int i = 0; i < 24; i++) step("mixed", 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
